// File: rtl/seq_shifter.sv
// ---------------------------------------------------------------------------
// seq_shifter
//
// Multi-cycle serial shift/rotate unit used by the execute stage. An operand
// is captured on a start request and then moved one bit position per clock
// until the latched count reaches zero. After that the result is published
// on data_out for one cycle, marked by a single-cycle done pulse.
//
// Parameters:
//   WIDTH  data width in bits (>= 2)
//   AMT_W  width of the shift-amount port. Amounts may exceed WIDTH.
//
// Ports:
//   clk        system clock. All state updates on the rising edge.
//   rst        synchronous active-high reset. Overrides every other input.
//   start      operation request. Sampled only while idle.
//   mode       00=SLL, 01=SRL, 10=SRA, 11=ROL. Sampled with start.
//   amt        shift count. Sampled with start.
//   data_in    operand. Sampled with start.
//   busy       high while an operation is shifting or presenting its result.
//   done       one-cycle pulse. The result is valid on data_out.
//   data_out   result register. Holds the last result until the next done.
//   state_dbg  registered FSM state (00=IDLE, 01=SHIFT, 10=DONE).
//
// Handshake: the requester raises start for one cycle while busy is low.
// The request is accepted on that edge, and busy rises on the next cycle.
// A start seen while busy is high is dropped and is not queued. The
// requester must wait for busy to fall before it issues a new request.
// done is asserted for exactly one cycle, and in that cycle data_out
// carries the result.
// ---------------------------------------------------------------------------
module seq_shifter #(
    parameter int WIDTH = 16,
    parameter int AMT_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       mode,
    input  logic [AMT_W-1:0] amt,
    input  logic [WIDTH-1:0] data_in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] data_out,
    output logic [1:0]       state_dbg
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_e;

    localparam logic [1:0] MODE_SLL = 2'b00;
    localparam logic [1:0] MODE_SRL = 2'b01;
    localparam logic [1:0] MODE_SRA = 2'b10;
    localparam logic [1:0] MODE_ROL = 2'b11;

    localparam logic [AMT_W-1:0] CNT_ONE = {{(AMT_W-1){1'b0}}, 1'b1};

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   work_q, work_d;
    logic [AMT_W-1:0]   cnt_q, cnt_d;
    logic [1:0]         mode_q, mode_d;
    logic [WIDTH-1:0]   data_out_q, data_out_d;
    logic [WIDTH-1:0]   step_d;

    // One-bit step of the working register. The step is selected by the
    // latched mode, so changes on the mode port during an operation have
    // no effect.
    always_comb begin
        step_d = work_q;
        case (mode_q)
            MODE_SLL: step_d = {work_q[WIDTH-2:0], 1'b0};
            MODE_SRL: step_d = {1'b0, work_q[WIDTH-1:1]};
            MODE_SRA: step_d = {work_q[WIDTH-1], work_q[WIDTH-1:1]};
            MODE_ROL: step_d = {work_q[WIDTH-2:0], work_q[WIDTH-1]};
            default:  step_d = work_q;
        endcase
    end

    // Next-state logic. Amounts of WIDTH or more need no special handling.
    // Repeated single steps saturate naturally: shifts reach zero or the
    // sign fill, and a rotate wraps modulo WIDTH.
    always_comb begin
        state_d    = state_q;
        work_d     = work_q;
        cnt_d      = cnt_q;
        mode_d     = mode_q;
        data_out_d = data_out_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    work_d  = data_in;
                    cnt_d   = amt;
                    mode_d  = mode;
                    state_d = S_SHIFT;
                end
            end

            S_SHIFT: begin
                if (cnt_q != '0) begin
                    // The count only decrements while non-zero, so it
                    // never wraps.
                    work_d = step_d;
                    cnt_d  = cnt_q - CNT_ONE;
                end else begin
                    data_out_d = work_q;
                    state_d    = S_DONE;
                end
            end

            S_DONE: begin
                // Back-to-back accept is not allowed here. A new request is
                // taken only in the idle cycle that follows.
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            work_q     <= '0;
            cnt_q      <= '0;
            mode_q     <= '0;
            data_out_q <= '0;
        end else begin
            state_q    <= state_d;
            work_q     <= work_d;
            cnt_q      <= cnt_d;
            mode_q     <= mode_d;
            data_out_q <= data_out_d;
        end
    end

    // Status is decoded from the registered state only, so there is no
    // combinational path from any input to any output.
    assign busy      = (state_q == S_SHIFT) || (state_q == S_DONE);
    assign done      = (state_q == S_DONE);
    assign data_out  = data_out_q;
    assign state_dbg = state_q;

endmodule

// File: tb/tb_seq_shifter.sv
// ---------------------------------------------------------------------------
// tb_seq_shifter
//
// Two instances share one stimulus stream. u_a uses the default AMT_W=4, so
// it sees only amt[3:0]. u_b uses AMT_W=5 and sees the full 5-bit amount.
// Every operation pushes a hand-computed result and an expected done cycle
// for each instance. A negedge monitor pops and compares these whenever
// that instance pulses done.
// ---------------------------------------------------------------------------
module tb_seq_shifter;

  localparam logic [1:0] M_SLL = 2'b00;
  localparam logic [1:0] M_SRL = 2'b01;
  localparam logic [1:0] M_SRA = 2'b10;
  localparam logic [1:0] M_ROL = 2'b11;

  // ---------------- clock / reset ----------------
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [1:0]  mode = 2'b00;
  logic [4:0]  amt = 5'd0;
  logic [15:0] data_in = 16'h0000;

  logic        busy_a, done_a, busy_b, done_b;
  logic [15:0] dout_a, dout_b;
  logic [1:0]  st_a, st_b;

  int cyc = 0;
  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  seq_shifter #(.WIDTH(16), .AMT_W(4)) u_a (
    .clk(clk), .rst(rst), .start(start), .mode(mode), .amt(amt[3:0]),
    .data_in(data_in), .busy(busy_a), .done(done_a), .data_out(dout_a),
    .state_dbg(st_a)
  );

  seq_shifter #(.WIDTH(16), .AMT_W(5)) u_b (
    .clk(clk), .rst(rst), .start(start), .mode(mode), .amt(amt),
    .data_in(data_in), .busy(busy_b), .done(done_b), .data_out(dout_b),
    .state_dbg(st_b)
  );

  // ---------------- scoreboard ----------------
  logic [15:0] exp_a_q[$];
  logic [15:0] exp_b_q[$];
  int          cyc_a_q[$];
  int          cyc_b_q[$];
  logic        prev_done_a = 1'b0;
  logic        prev_done_b = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (done_a) begin
      check("a_done_width", {31'd0, prev_done_a}, 32'd0);
      if (exp_a_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL a_unexpected_done: got done with data_out 0x%0h expected no done (cycle %0d)", dout_a, cyc);
      end else begin
        check("a_data_out", {16'd0, dout_a}, {16'd0, exp_a_q.pop_front()});
        check("a_done_cycle", cyc, cyc_a_q.pop_front());
      end
    end
    if (done_b) begin
      check("b_done_width", {31'd0, prev_done_b}, 32'd0);
      if (exp_b_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL b_unexpected_done: got done with data_out 0x%0h expected no done (cycle %0d)", dout_b, cyc);
      end else begin
        check("b_data_out", {16'd0, dout_b}, {16'd0, exp_b_q.pop_front()});
        check("b_done_cycle", cyc, cyc_b_q.pop_front());
      end
    end
    prev_done_a = done_a;
    prev_done_b = done_b;
  end

  // ---------------- driver tasks ----------------
  task automatic wait_idle();
    int k;
    k = 0;
    @(negedge clk);
    while ((busy_a || busy_b) && k < 200) begin
      @(negedge clk);
      k++;
    end
    if (k >= 200) begin
      n_cmp++;
      n_err++;
      $display("FAIL idle_timeout: got busy still high expected idle within 200 cycles");
    end
  endtask

  // Raise start for one edge (E0) and return the cycle stamp taken just
  // after E0.
  task automatic issue(input logic [1:0] m, input logic [4:0] a,
                       input logic [15:0] d, output int c0);
    mode    = m;
    amt     = a;
    data_in = d;
    start   = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    c0    = cyc;
  endtask

  task automatic do_op(input logic [1:0] m, input logic [4:0] a, input logic [15:0] d,
                       input logic [15:0] exp_a, input logic [15:0] exp_b);
    int c0;
    wait_idle();
    issue(m, a, d, c0);
    exp_a_q.push_back(exp_a);
    cyc_a_q.push_back(c0 + int'(a[3:0]) + 1);
    exp_b_q.push_back(exp_b);
    cyc_b_q.push_back(c0 + int'(a) + 1);
    check("a_busy_after_start", {31'd0, busy_a}, 32'd1);
    check("b_busy_after_start", {31'd0, busy_b}, 32'd1);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int c0;

    // Reset for three edges, then check the reset state.
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_a_busy", {31'd0, busy_a}, 32'd0);
    check("rst_a_done", {31'd0, done_a}, 32'd0);
    check("rst_a_dout", {16'd0, dout_a}, 32'd0);
    check("rst_a_state", {30'd0, st_a}, 32'd0);
    check("rst_b_dout", {16'd0, dout_b}, 32'd0);
    rst = 1'b0;

    // SRL basics.
    do_op(M_SRL, 5'd1, 16'h0002, 16'h0001, 16'h0001);
    do_op(M_SRL, 5'd2, 16'h0002, 16'h0000, 16'h0000);

    // SLL / SRL on runs of ones.
    do_op(M_SLL, 5'd2, 16'hFFFF, 16'hFFFC, 16'hFFFC);
    do_op(M_SRL, 5'd2, 16'h000F, 16'h0003, 16'h0003);

    // SRA and ROL.
    do_op(M_SRA, 5'd3, 16'h8000, 16'hF000, 16'hF000);
    do_op(M_ROL, 5'd1, 16'h8001, 16'h0003, 16'h0003);
    do_op(M_ROL, 5'd15, 16'h1234, 16'h091A, 16'h091A);
    do_op(M_SRA, 5'd15, 16'h7FFF, 16'h0000, 16'h0000);

    // Amounts at or above WIDTH. u_a sees amt[3:0].
    do_op(M_ROL, 5'd16, 16'h1234, 16'h1234, 16'h1234);
    do_op(M_SLL, 5'd20, 16'hFFFF, 16'hFFF0, 16'h0000);
    do_op(M_SRA, 5'd31, 16'h8000, 16'hFFFF, 16'hFFFF);
    do_op(M_SRL, 5'd17, 16'hFFFF, 16'h7FFF, 16'h0000);
    do_op(M_ROL, 5'd20, 16'h1234, 16'h2341, 16'h2341);

    // amt=0 followed by a hold while data_in toggles.
    do_op(M_SRA, 5'd0, 16'h00A5, 16'h00A5, 16'h00A5);
    wait_idle();
    for (int i = 0; i < 10; i++) begin
      data_in = ~data_in;
      mode    = 2'(i);
      @(negedge clk);
      check("hold_a_dout", {16'd0, dout_a}, 32'h00A5);
      check("hold_b_dout", {16'd0, dout_b}, 32'h00A5);
    end

    // Starts that arrive while busy are ignored. Pulses are sent in the
    // cycles after E2 and after E6, and the cycle after E6 is DONE.
    wait_idle();
    issue(M_SLL, 5'd5, 16'h0001, c0);
    exp_a_q.push_back(16'h0020);
    cyc_a_q.push_back(c0 + 6);
    exp_b_q.push_back(16'h0020);
    cyc_b_q.push_back(c0 + 6);
    repeat (3) @(negedge clk);
    mode = M_ROL; amt = 5'd3; data_in = 16'hAAAA; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (4) @(negedge clk);
    check("a_in_done_state", {30'd0, st_a}, 32'd2);
    mode = M_SRL; amt = 5'd1; data_in = 16'h5555; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    // A start one cycle after done is accepted.
    do_op(M_SRL, 5'd15, 16'h8000, 16'h0001, 16'h0001);

    // Reset in the middle of an operation. rst is sampled on E4.
    wait_idle();
    issue(M_SRL, 5'd10, 16'hFFFF, c0);
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("midrst_a_busy", {31'd0, busy_a}, 32'd0);
    check("midrst_a_done", {31'd0, done_a}, 32'd0);
    check("midrst_a_dout", {16'd0, dout_a}, 32'd0);
    check("midrst_b_busy", {31'd0, busy_b}, 32'd0);
    check("midrst_b_dout", {16'd0, dout_b}, 32'd0);
    rst = 1'b0;
    repeat (15) @(negedge clk);
    check("midrst_a_dout_held", {16'd0, dout_a}, 32'd0);

    do_op(M_SRA, 5'd4, 16'h8001, 16'hF800, 16'hF800);

    wait_idle();
    repeat (2) @(negedge clk);
    check("a_queue_drained", exp_a_q.size(), 32'd0);
    check("b_queue_drained", exp_b_q.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no completion expected finish before 200000 time units");
    $fatal(1, "watchdog expired");
  end

endmodule
